// File: rtl/calc1_pkg.sv
// Shared calc1 definitions: command/response codes and the port-driver FSM state.
package calc1_pkg;

    localparam logic [0:3] CMD_NOP = 4'd0;
    localparam logic [0:3] CMD_ADD = 4'd1;
    localparam logic [0:3] CMD_SUB = 4'd2;
    localparam logic [0:3] CMD_SHL = 4'd5;
    localparam logic [0:3] CMD_SHR = 4'd6;

    localparam logic [0:1] RESP_NONE   = 2'b00;
    localparam logic [0:1] RESP_OK     = 2'b01;
    localparam logic [0:1] RESP_ERR    = 2'b10;
    localparam logic [0:1] RESP_UNUSED = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_WAIT,
        ST_DONE
    } calc1_state_e;

endpackage

// File: rtl/calc1_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all ones instead of wrapping.
module calc1_sat_counter #(
    parameter int W = 16
) (
    input  logic         c_clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/calc1_port_driver.sv
// Initiator for one calc1 request port: serialises an operation into the two-cycle
// calc1 request, waits for the response (or a timeout) and hands the result upstream.
module calc1_port_driver
    import calc1_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic             c_clk,
    input  logic             reset,
    // Both op_* and res_* are valid/ready: a transfer happens on a posedge where valid
    // and ready are both high; valid side holds its payload stable until that edge.
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [0:3]       op_cmd,
    input  logic [0:31]      op_data1,
    input  logic [0:31]      op_data2,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [0:1]       res_resp,
    output logic [0:31]      res_data,
    output logic             res_timeout,
    output logic [0:3]       req_cmd_out,
    output logic [0:31]      req_data_out,
    input  logic [0:1]       calc_resp,
    input  logic [0:31]      calc_data,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_issued,
    output logic [CNT_W-1:0] cnt_errors,
    output calc1_state_e     dbg_state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    calc1_state_e  state;
    logic [0:31]   op2_q;
    logic [TW-1:0] tmo_q;
    logic          tmo_last;
    logic          resp_hit;
    logic          err_inc;

    assign dbg_state = state;
    assign tmo_last  = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign resp_hit  = (calc_resp != RESP_NONE);

    // Inside WAIT a response beats a same-cycle timeout; outside WAIT any response is spurious.
    assign err_inc = (state == ST_WAIT) ? (resp_hit ? calc_resp[0] : tmo_last) : resp_hit;

    calc1_sat_counter #(.W(CNT_W)) u_cnt_issued (
        .c_clk (c_clk),
        .reset (reset),
        .inc   (state == ST_CMD),
        .clr   (1'b0),
        .q     (cnt_issued)
    );

    calc1_sat_counter #(.W(CNT_W)) u_cnt_errors (
        .c_clk (c_clk),
        .reset (reset),
        .inc   (err_inc),
        .clr   (1'b0),
        .q     (cnt_errors)
    );

    calc1_sat_counter #(.W(TW)) u_tmo (
        .c_clk (c_clk),
        .reset (reset),
        .inc   (state == ST_WAIT),
        .clr   (state != ST_WAIT),
        .q     (tmo_q)
    );

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            op_ready     <= 1'b0;
            busy         <= 1'b0;
            req_cmd_out  <= '0;
            req_data_out <= '0;
            res_valid    <= 1'b0;
            res_resp     <= RESP_NONE;
            res_data     <= '0;
            res_timeout  <= 1'b0;
            op2_q        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    op_ready <= 1'b1;
                    if (op_valid && op_ready) begin
                        op_ready    <= 1'b0;
                        busy        <= 1'b1;
                        op2_q       <= op_data2;
                        res_timeout <= 1'b0;
                        if (op_cmd != CMD_NOP) begin
                            state        <= ST_CMD;
                            req_cmd_out  <= op_cmd;
                            req_data_out <= op_data1;
                        end else begin
                            state     <= ST_DONE;
                            res_valid <= 1'b1;
                            res_resp  <= RESP_NONE;
                            res_data  <= '0;
                        end
                    end
                end
                ST_CMD: begin
                    state        <= ST_DATA;
                    req_cmd_out  <= '0;
                    req_data_out <= op2_q;
                end
                ST_DATA: begin
                    state        <= ST_WAIT;
                    req_data_out <= '0;
                end
                ST_WAIT: begin
                    if (resp_hit) begin
                        state     <= ST_DONE;
                        res_valid <= 1'b1;
                        res_resp  <= calc_resp;
                        res_data  <= calc_data;
                    end else if (tmo_last) begin
                        state       <= ST_DONE;
                        res_valid   <= 1'b1;
                        res_resp    <= RESP_NONE;
                        res_data    <= '0;
                        res_timeout <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state     <= ST_IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        op_ready  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
